// File: rtl/arb_pkg.sv
// arb_pkg -- shared definitions for the instruction/data memory arbiter.
//
// Contents:
//   arb_state_t   arbiter FSM state encoding (IDLE, GRANT_I, GRANT_D, RESP)
//   DM_*          dm_ctrl access-size codes carried on d_ctrl / m_ctrl
//
// Fetches always present DM_NONE on the memory port, so that code must stay 0.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RESP    = 2'd3
  } arb_state_t;

  localparam logic [2:0] DM_NONE   = 3'd0;
  localparam logic [2:0] DM_BYTE   = 3'd1;
  localparam logic [2:0] DM_HALF   = 3'd2;
  localparam logic [2:0] DM_WORD   = 3'd3;
  localparam logic [2:0] DM_BYTE_U = 3'd4;
  localparam logic [2:0] DM_HALF_U = 3'd5;

endpackage

// File: rtl/arb_starve_cnt.sv
// arb_starve_cnt -- anti-starvation counter for the fetch requester.
//
// Counts data grants issued while a fetch is waiting and saturates at
// STARVE_MAX; any fetch grant clears it. 'starve' tells the arbiter to hand
// the next IDLE arbitration to the fetch side.
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous, active-low reset
//   data_grant   arbiter is granting the data requester this cycle
//   fetch_grant  arbiter is granting the fetch requester this cycle
//   i_req        fetch request (a data grant only counts while fetch waits)
//   starve       count has reached STARVE_MAX
module arb_starve_cnt
  import arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic data_grant,
  input  logic fetch_grant,
  input  logic i_req,
  output logic starve
);

  // At least one bit even for a degenerate STARVE_MAX of 0.
  localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] count;

  // Saturating count of data grants that jumped ahead of a waiting fetch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (fetch_grant) begin
      count <= '0;
    end else if (data_grant && i_req && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign starve = (count == CNT_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter -- shares one memory port between instruction fetch and data.
//
// Data requests normally win; a fetch is granted only when no data request is
// pending (or, with fairness enabled, once the fetch side has been starved).
// One transaction at a time: IDLE -> GRANT_x (m_req held until m_ready) ->
// RESP (owner's ack pulse) -> IDLE.
//
// Configuration macro:
//   ARB_FAIRNESS_EN  compile in arb_starve_cnt; after STARVE_MAX consecutive
//                    data grants with a fetch waiting, the fetch wins.
//
// Ports:
//   clk, reset                   clock (rising edge), async active-low reset
//   i_req/i_addr/i_flush         fetch request, address, kill in-flight fetch
//   i_ack/i_rdata                fetch completion pulse, instruction word
//   d_req/d_we/d_addr/d_wdata/d_ctrl  data request, write enable, address,
//                                store data, dm_ctrl size code
//   d_ack/d_rdata                data completion pulse, load data
//   m_req/m_we/m_addr/m_wdata/m_ctrl  shared memory request port
//   m_ready/m_rdata              memory completion, read data
//   stall_if/stall_mem           pipeline hold requests
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_flush,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [2:0]        d_ctrl,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [2:0]        m_ctrl,
  input  logic              m_ready,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  arb_state_t state;
  logic       owner_d;
  logic       fetch_flushed;
  logic       fetch_ok;
  logic       force_fetch;
  logic       take_d;
  logic       take_i;

`ifdef ARB_FAIRNESS_EN
  logic starve;

  arb_starve_cnt #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_cnt (
    .clk         (clk),
    .reset       (reset),
    .data_grant  (take_d),
    .fetch_grant (take_i),
    .i_req       (i_req),
    .starve      (starve)
  );

  assign force_fetch = starve;
`else
  // Strict data priority; STARVE_MAX only matters to the fairness build.
  logic unused_starve_max;
  assign unused_starve_max = |STARVE_MAX;
  assign force_fetch = 1'b0;
`endif

  // A flush in IDLE blocks the fetch; if that fetch was being forced, the
  // data side is allowed to use the otherwise idle cycle.
  assign fetch_ok = i_req & ~i_flush;
  assign take_d   = (state == IDLE) & d_req & ~(force_fetch & fetch_ok);
  assign take_i   = (state == IDLE) & fetch_ok & (~d_req | force_fetch);

  // Arbiter FSM; the memory port is driven from registers latched at grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      owner_d       <= 1'b0;
      fetch_flushed <= 1'b0;
      m_req         <= 1'b0;
      m_we          <= 1'b0;
      m_addr        <= '0;
      m_wdata       <= '0;
      m_ctrl        <= DM_NONE;
      i_rdata       <= '0;
      d_rdata       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take_d) begin
            state         <= GRANT_D;
            owner_d       <= 1'b1;
            fetch_flushed <= 1'b0;
            m_req         <= 1'b1;
            m_we          <= d_we;
            m_addr        <= d_addr;
            m_wdata       <= d_wdata;
            m_ctrl        <= d_ctrl;
          end else if (take_i) begin
            state         <= GRANT_I;
            owner_d       <= 1'b0;
            fetch_flushed <= 1'b0;
            m_req         <= 1'b1;
            m_we          <= 1'b0;
            m_addr        <= i_addr;
            m_wdata       <= '0;
            m_ctrl        <= DM_NONE;
          end
        end
        GRANT_I, GRANT_D: begin
          // A flushed fetch still runs to completion, only its ack is dropped.
          if ((state == GRANT_I) && i_flush) begin
            fetch_flushed <= 1'b1;
          end
          if (m_ready) begin
            state <= RESP;
            m_req <= 1'b0;
            m_we  <= 1'b0;
            if (owner_d) begin
              d_rdata <= m_rdata;
            end else begin
              i_rdata <= m_rdata;
            end
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // i_flush during the RESP cycle itself also kills the fetch ack.
  assign i_ack     = (state == RESP) & ~owner_d & ~fetch_flushed & ~i_flush;
  assign d_ack     = (state == RESP) & owner_d;
  assign stall_if  = i_req & ~i_ack;
  assign stall_mem = d_req & ~d_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter -- self-checking bench for mem_arbiter.
//
// A transaction-level model (one outstanding transaction, its memory phase,
// its ack phase) predicts every output each cycle; directed sequences add
// literal expectations, then a long randomized run exercises the rest.
// Define ARB_FAIRNESS_EN for both RTL and bench to check the fairness build.
module tb_mem_arbiter;
  import arb_pkg::*;

  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_flush;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [2:0]  d_ctrl;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [2:0]  m_ctrl;
  logic        m_ready;
  logic [31:0] m_rdata;
  logic        stall_if;
  logic        stall_mem;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .STARVE_MAX (STARVE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_flush   (i_flush),
    .i_ack     (i_ack),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ctrl    (d_ctrl),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .m_req     (m_req),
    .m_we      (m_we),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_ctrl    (m_ctrl),
    .m_ready   (m_ready),
    .m_rdata   (m_rdata),
    .stall_if  (stall_if),
    .stall_mem (stall_mem)
  );

  always #5 clk = ~clk;

  // Reference model: the one transaction in flight and its progress.
  typedef struct packed {
    logic        is_data;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  ctrl;
  } txn_t;

  txn_t        cur;
  bit          busy      = 1'b0;
  bit          mem_done  = 1'b0;
  bit          flushed   = 1'b0;
  int          starve    = 0;
  logic [31:0] exp_irdata = '0;
  logic [31:0] exp_drdata = '0;
  logic [31:0] exp_maddr  = '0;
  logic [31:0] exp_mwdata = '0;
  logic [2:0]  exp_mctrl  = '0;
  bit          e_iack;
  bit          e_dack;
  bit          e_mreq;

  task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs for the current cycle from model state plus live inputs.
  task automatic checkOutput();
    bit live;
    bit resp;
    live   = (reset === 1'b1);
    e_mreq = live && busy && !mem_done;
    resp   = live && busy && mem_done;
    e_iack = resp && !cur.is_data && !flushed && !i_flush;
    e_dack = resp && cur.is_data;
    checkValue("m_req",     m_req,     e_mreq);
    checkValue("m_we",      m_we,      e_mreq && cur.we);
    checkValue("m_addr",    m_addr,    live ? exp_maddr  : 32'h0);
    checkValue("m_wdata",   m_wdata,   live ? exp_mwdata : 32'h0);
    checkValue("m_ctrl",    m_ctrl,    live ? exp_mctrl  : 3'h0);
    checkValue("i_ack",     i_ack,     e_iack);
    checkValue("d_ack",     d_ack,     e_dack);
    checkValue("i_rdata",   i_rdata,   live ? exp_irdata : 32'h0);
    checkValue("d_rdata",   d_rdata,   live ? exp_drdata : 32'h0);
    checkValue("stall_if",  stall_if,  i_req && !e_iack);
    checkValue("stall_mem", stall_mem, d_req && !e_dack);
  endtask

  // Advance the model by one rising edge using the inputs seen at that edge.
  task automatic modelStep();
    bit fetch_ok;
    bit force_fetch;
    if (reset !== 1'b1) begin
      busy = 0; mem_done = 0; flushed = 0; starve = 0; cur = '0;
      exp_irdata = '0; exp_drdata = '0; exp_maddr = '0; exp_mwdata = '0; exp_mctrl = '0;
      return;
    end
    if (!busy) begin
      fetch_ok    = i_req && !i_flush;
      force_fetch = 1'b0;
`ifdef ARB_FAIRNESS_EN
      force_fetch = (starve >= STARVE);
`endif
      if (d_req && !(force_fetch && fetch_ok)) begin
        cur = '{is_data: 1'b1, we: d_we, addr: d_addr, wdata: d_wdata, ctrl: d_ctrl};
        busy = 1; mem_done = 0; flushed = 0;
        if (i_req && starve < STARVE) starve++;
      end else if (fetch_ok) begin
        cur = '{is_data: 1'b0, we: 1'b0, addr: i_addr, wdata: 32'h0, ctrl: DM_NONE};
        busy = 1; mem_done = 0; flushed = 0;
        starve = 0;
      end
      if (busy) begin
        exp_maddr = cur.addr; exp_mwdata = cur.wdata; exp_mctrl = cur.ctrl;
      end
    end else if (!mem_done) begin
      if (!cur.is_data && i_flush) flushed = 1;
      if (m_ready) begin
        mem_done = 1;
        if (cur.is_data) exp_drdata = m_rdata;
        else             exp_irdata = m_rdata;
      end
    end else begin
      busy = 0;
    end
  endtask

  // Called just after a falling edge: optionally randomize inputs, settle, check.
  task automatic applyStimulus(input bit rnd);
    if (rnd) begin
      reset   = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      i_req   = ($urandom_range(0, 99) < 65);
      i_addr  = $urandom;
      i_flush = ($urandom_range(0, 99) < 8);
      d_req   = ($urandom_range(0, 99) < 45);
      d_we    = 1'($urandom_range(0, 1));
      d_addr  = $urandom;
      d_wdata = $urandom;
      d_ctrl  = 3'($urandom_range(0, 7));
      m_ready = ($urandom_range(0, 99) < 40);
      m_rdata = $urandom;
    end
    #1;
    checkOutput();
  endtask

  task automatic stepClock();
    @(posedge clk);
    modelStep();
    @(negedge clk);
  endtask

  task automatic setQuiet();
    reset = 1'b1; i_req = 0; i_addr = '0; i_flush = 0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_ctrl = DM_NONE;
    m_ready = 0; m_rdata = '0;
  endtask

  task automatic doReset();
    setQuiet(); reset = 1'b0; applyStimulus(0); stepClock();
    reset = 1'b1; applyStimulus(0); stepClock();
  endtask

  // Let any outstanding transaction finish with no new requests.
  task automatic drain();
    for (int k = 0; k < 3; k++) begin
      setQuiet(); m_ready = 1; applyStimulus(0); stepClock();
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] grants [5];
    int          ngrant;

    setQuiet();
    reset = 1'b0;
    @(negedge clk);
    applyStimulus(0);
    checkValue("rst_m_req",   m_req,   0);
    checkValue("rst_i_ack",   i_ack,   0);
    checkValue("rst_m_addr",  m_addr,  0);
    checkValue("rst_d_rdata", d_rdata, 0);
    stepClock();
    reset = 1'b1; applyStimulus(0); stepClock();

    // Single fetch at minimum latency.
    setQuiet(); i_req = 1; i_addr = 32'h100; applyStimulus(0); stepClock();
    m_ready = 1; m_rdata = 32'h00500093; applyStimulus(0);
    checkValue("f_m_req",  m_req,  1);
    checkValue("f_m_addr", m_addr, 32'h100);
    checkValue("f_m_we",   m_we,   0);
    checkValue("f_m_ctrl", m_ctrl, 0);
    stepClock();
    i_req = 0; m_ready = 0; applyStimulus(0);
    checkValue("f_i_ack",       i_ack,   1);
    checkValue("f_i_rdata",     i_rdata, 32'h00500093);
    checkValue("f_model_iack",  e_iack,  1);
    checkValue("f_model_rdata", exp_irdata, 32'h00500093);
    stepClock();
    applyStimulus(0);
    checkValue("f_ack_once", i_ack, 0);
    stepClock();

    // Simultaneous requests: data store first, then the fetch.
    setQuiet(); i_req = 1; i_addr = 32'h200;
    d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hDEAD; d_ctrl = DM_WORD;
    applyStimulus(0); stepClock();
    m_ready = 1; m_rdata = 32'h11; applyStimulus(0);
    checkValue("p_m_we",      m_we,      1);
    checkValue("p_m_addr",    m_addr,    32'h40);
    checkValue("p_m_wdata",   m_wdata,   32'hDEAD);
    checkValue("p_stall_if",  stall_if,  1);
    stepClock();
    d_req = 0; m_ready = 0; applyStimulus(0);
    checkValue("p_d_ack", d_ack, 1);
    stepClock();
    applyStimulus(0); stepClock();
    m_ready = 1; m_rdata = 32'h22; applyStimulus(0);
    checkValue("p_fetch_m_addr", m_addr, 32'h200);
    checkValue("p_fetch_m_we",   m_we,   0);
    stepClock();
    i_req = 0; m_ready = 0; applyStimulus(0);
    checkValue("p_i_ack", i_ack, 1);
    stepClock();

    // Slow memory: five wait cycles on a load.
    setQuiet(); d_req = 1; d_addr = 32'h80; d_ctrl = DM_WORD; applyStimulus(0); stepClock();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0);
      checkValue("w_m_req",     m_req,     1);
      checkValue("w_m_addr",    m_addr,    32'h80);
      checkValue("w_stall_mem", stall_mem, 1);
      stepClock();
    end
    m_ready = 1; m_rdata = 32'h1234; applyStimulus(0); stepClock();
    d_req = 0; m_ready = 0; applyStimulus(0);
    checkValue("w_d_ack",   d_ack,   1);
    checkValue("w_d_rdata", d_rdata, 32'h1234);
    stepClock();

    // Flushed fetch: memory completes, no ack, arbiter free again.
    setQuiet(); i_req = 1; i_addr = 32'h300; applyStimulus(0); stepClock();
    i_flush = 1; applyStimulus(0); stepClock();
    i_flush = 0; m_ready = 1; m_rdata = 32'hAA; applyStimulus(0); stepClock();
    i_req = 0; m_ready = 0; applyStimulus(0);
    checkValue("fl_i_ack",   i_ack,   0);
    checkValue("fl_i_rdata", i_rdata, 32'hAA);
    stepClock();
    i_req = 1; i_addr = 32'h304; applyStimulus(0); stepClock();
    m_ready = 1; applyStimulus(0);
    checkValue("fl_regrant", m_addr, 32'h304);
    stepClock();
    drain();

    // Reset in the middle of a data grant.
    setQuiet(); d_req = 1; d_addr = 32'h44; applyStimulus(0); stepClock();
    applyStimulus(0);
    checkValue("r_m_req_before", m_req, 1);
    reset = 1'b0; applyStimulus(0);
    checkValue("r_m_req_now", m_req, 0);
    checkValue("r_d_ack",     d_ack, 0);
    stepClock();
    reset = 1'b1; applyStimulus(0);
    checkValue("r_after_d_ack", d_ack, 0);
    stepClock();
    applyStimulus(0);
    checkValue("r_first_grant", m_req, 1);
    stepClock();
    drain();

    // Starvation: data always requesting, fetch waiting, fast memory.
    doReset();
    setQuiet(); i_req = 1; i_addr = 32'h500; d_req = 1; d_addr = 32'h600; m_ready = 1;
    ngrant = 0;
    for (int k = 0; k < 20 && ngrant < 5; k++) begin
      applyStimulus(0);
      if (m_req === 1'b1) begin
        grants[ngrant] = m_addr;
        ngrant++;
      end
      stepClock();
    end
    checkValue("s_grant_count", ngrant, 5);
    for (int k = 0; k < 4; k++) checkValue("s_data_grant", grants[k], 32'h600);
`ifdef ARB_FAIRNESS_EN
    checkValue("s_fifth_grant", grants[4], 32'h500);
`else
    checkValue("s_fifth_grant", grants[4], 32'h600);
`endif
    drain();

    $display("[TB] directed phase done, starting random phase");
    for (int n = 0; n < 2000; n++) begin
      applyStimulus(1);
      stepClock();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter STARVE_MAX, default 4, consecutive data grants tolerated while fetch waits.
REQ-004 SHALL have port clk  in  1  single clock, rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports i_req in 1, i_addr in ADDR_W, i_flush in 1: fetch request, address, kill in-flight fetch.
REQ-007 SHALL have ports i_ack out 1, i_rdata out DATA_W: fetch completion pulse, instruction.
REQ-008 SHALL have ports d_req in 1, d_we in 1, d_addr in ADDR_W, d_wdata in DATA_W, d_ctrl in 3: data request, write enable, address, store data, dm_ctrl size code.
REQ-009 SHALL have ports d_ack out 1, d_rdata out DATA_W: data completion pulse, load data.
REQ-010 SHALL have ports m_req out 1, m_we out 1, m_addr out ADDR_W, m_wdata out DATA_W, m_ctrl out 3: shared memory port.
REQ-011 SHALL have ports m_ready in 1, m_rdata in DATA_W: memory completion, read data.
REQ-012 SHALL have ports stall_if out 1, stall_mem out 1: pipeline hold requests.

Function
REQ-013 SHALL implement FSM states IDLE, GRANT_I, GRANT_D, RESP.
REQ-014 IDLE: d_req -> GRANT_D; else i_req -> GRANT_I; neither -> stay IDLE.
REQ-015 On entering GRANT_x SHALL latch owner's addr/we/wdata/ctrl; m_req=1 and m_* driven from latch for the whole GRANT state.
REQ-016 Fetch grants SHALL drive m_we=0, m_ctrl=0.
REQ-017 GRANT_x with m_ready=1 -> RESP, capturing m_rdata into owner's rdata register; m_ready=0 -> hold state.
REQ-018 RESP SHALL pulse owner's ack for exactly one cycle, then -> IDLE; rdata stable until next owner capture.
REQ-019 Minimum latency: req sampled cycle T, m_req at T+1, ack at T+2 when m_ready at T+1.
REQ-020 stall_if SHALL be i_req & ~i_ack; stall_mem SHALL be d_req & ~d_ack (combinational).
REQ-021 i_flush high in any cycle of GRANT_I or RESP-for-fetch SHALL suppress that i_ack; memory transaction still completes.
REQ-022 i_flush in IDLE SHALL block a fetch grant that cycle.
REQ-023 Requester deasserting req mid-transaction SHALL NOT abort it; ack still pulses.
REQ-024 m_ready outside GRANT states SHALL be ignored.
REQ-025 Simultaneous d_req and i_req in IDLE: data wins unless REQ-030 forces fetch.

Reset
REQ-026 reset low SHALL immediately force IDLE, m_req=0, m_we=0, i_ack=0, d_ack=0.
REQ-027 reset SHALL clear m_addr, m_wdata, m_ctrl, i_rdata, d_rdata, starvation counter to 0.
REQ-028 Reset mid-transaction SHALL drop it without ack; first grant possible in the cycle after reset deasserts.

Configuration
REQ-029 Macro ARB_FAIRNESS_EN SHALL compile in an anti-starvation counter.
REQ-030 With ARB_FAIRNESS_EN: counter increments per data grant while i_req=1, clears on fetch grant; at STARVE_MAX, next IDLE arbitration grants fetch even if d_req=1.
REQ-031 Without ARB_FAIRNESS_EN: strict data priority, no counter logic.

Structure
REQ-032 FSM state typedef and state encodings SHALL live in shared package arb_pkg with dm_ctrl codes.
REQ-033 Optional sub-module arb_starve_cnt holds the fairness counter; instantiated only under ARB_FAIRNESS_EN.

Verification
REQ-034 i_req=1, i_addr=0x100, m_ready at T+1, m_rdata=0x00500093 -> i_ack at T+2, i_rdata=0x00500093.
REQ-035 i_req and d_req same cycle, d_we=1, d_addr=0x40, d_wdata=0xDEAD -> m_we=1, m_addr=0x40 first; d_ack, then fetch granted.
REQ-036 m_ready held low 5 cycles -> m_req/m_addr stable, stall_mem=1 throughout, d_ack one cycle after m_ready.
REQ-037 i_flush=1 during GRANT_I -> no i_ack, FSM returns IDLE after RESP.
REQ-038 ARB_FAIRNESS_EN, STARVE_MAX=4, d_req constantly 1, i_req=1 -> fifth grant goes to fetch.
REQ-039 reset low during GRANT_D -> m_req=0 same cycle, no d_ack, IDLE after release.
